denise_sprite_shifter_gen: RTL
==============================

// Module: denise_sprite_shifter_gen
// PURPOSE
//  Parametrised next-generation sprite parallel-to-serial converter for Denise.
//  - Holds POS/CTL/DATA/DATB for one sprite and arms it on a DATA write.
//  - Loads data at the horizontal start and serialises 16/32/64-bit fetches.
//  - Tracks the remaining pixel count; output is valid only while the sprite is active.
//  - Supports per-pixel magnification (1x/2x/4x).
//  - One instance per sprite channel inside the Denise sprite unit.
// PARAMETERS
//  FETCH_MAX  64  widest supported fetch in bits; legal values 16, 32, 64
//  LOAD_DLY   1   clk7_en ticks from hstart match to shift-register load (1..3)
// PORTS
//  clk       in   1   28MHz clock
//  reset     in   1   synchronous, active-high reset
//  clk7_en   in   1   7MHz enable; all register writes and the load pipeline advance only on it
//  aen       in   1   register address enable
//  address   in   2   00 POS, 01 CTL, 10 DATA, 11 DATB
//  hpos      in   9   horizontal beam counter
//  fmode     in   16  [3:2] sprite fetch width; [15] ignore hstart[8] in compare
//  mag       in   2   00 1x, 01 2x, 10 4x, 11 reserved (treated as 4x)
//  shift     in   1   pixel shift strobe (may occur every clk)
//  chip48    in   48  extra fetch data beyond data_in for wide fetches
//  data_in   in   16  bus data
//  sprdata   out  2   {B,A} serial pixel; 2'b00 whenever active=0
//  attach    out  1   CTL bit 7
//  active    out  1   shift register holds unshifted pixels
// BEHAVIOUR
//  Reset values: armed=0, active=0, sprdata=0, attach=0, hstart=0, latches=0, shifters=0, counters=0.
//  Effective width W: fmode[3:2]=00 -> 16; 01/10 -> 32; 11 -> 64. W is clipped to FETCH_MAX.
//  Data latching: a DATA/DATB write stores {data_in, chip48[47:64-W]} MSB-aligned; unused LSBs = 0.
//  Arming: a CTL write clears armed; a DATA write sets armed. CTL and DATA writes never coincide (one address).
//  Start match (per clk7_en tick): armed && hpos[7:0]==hstart[7:0] && (fmode[15] || hpos[8]==hstart[8]).
//  Load pipeline: the match passes through a LOAD_DLY-stage pipeline clocked by clk7_en.
//  Load action (pipeline output, on clk7_en):
//   - copy latches to shifta/shiftb
//   - pix_cnt <= W; hold_cnt <= 0; active <= 1
//   - W is sampled at load time
//  Shift action (shift=1, no load this clk):
//   - hold_cnt counts to 2^mag-1
//   - on wrap: shift both registers left 1 with 0 fill, and decrement pix_cnt
//   - when pix_cnt reaches 0: active <= 0 on the same edge
//  shift while active=0: no effect.
//  Load and shift in the same clk: load wins; the shift is discarded.
//  Re-trigger while active: a new load restarts from the fresh latches and discards the remaining pixels.
//  CTL write while active: disarms future loads only; the current sprite finishes shifting.
//  A DATA write during shifting changes the latch only; the shifter is unaffected.
//  Changing mag mid-sprite takes effect at the next hold_cnt wrap.
//  Reset asserted mid-sprite: all state returns to reset values on that edge.
//  Output: sprdata = active ? {shiftb[MSB], shifta[MSB]} : 2'b00. Combinational from registers; zero latency after load.
//  Counter widths: pix_cnt is $clog2(FETCH_MAX)+1 bits; hold_cnt is 2 bits.
// CONFIGURATION
//  SPR_FINE_HPOS_EN defined:
//   - hstart is extended with 2 sub-lores LSBs from CTL[4:3] (shres quarter pixels).
//   - After load, shifting is suppressed for the first hstart_fine shift strobes
//     (a shres pixel offset of 0..3).
//   - active rises at load; sprdata stays 0 until the offset expires.
//  SPR_FINE_HPOS_EN undefined:
//   - CTL[4:3] is ignored and no offset is applied.
// TESTING
//  1. POS=8'h40, CTL=0, DATB=16'h0F0F, DATA=16'hFFFF, fmode=0, mag=0, continuous shift, hpos sweeps
//     -> load LOAD_DLY ticks after hpos=0x80; sprdata B-bit alternates 0000_1111 and A-bit is 1 for 16 pixels;
//     active falls after the 16th shift; sprdata=00 afterwards.
//  2. fmode[3:2]=11, data_in=16'h8000, chip48=48'h0000_0000_0001
//     -> exactly 64 pixels: A=1 at pixel 0 and pixel 63, 0 elsewhere; active low at pixel 64.
//  3. mag=2'b01, DATA=16'hA000 -> sprdata A sequence 1,1,0,0,1,1,0,0, then 0; active lasts 32 shift strobes.
//  4. CTL write after arming, before the match -> no load and active stays 0;
//     DATA rewrite re-arms and the next line loads.
//  5. Second hstart match while 5 pixels remain -> pix_cnt reloads to W and new data appears;
//     load and shift in the same clk -> no bit is lost from the new data.
//  6. reset pulse at pixel 7 -> sprdata=00, active=0, attach=0 on the next edge;
//     no load until a new DATA write occurs.
//     With SPR_FINE_HPOS_EN, CTL[4:3]=2 -> first visible pixel delayed by 2 shift strobes.

Source files
------------

// File: rtl/denise_sprite_shifter_gen.sv
// denise_sprite_shifter_gen
// Sprite parallel-to-serial converter for one Denise sprite channel.
// Holds POS/CTL/DATA/DATB, arms on a DATA write, loads the shift registers
// LOAD_DLY 7MHz ticks after the horizontal start match and serialises a
// 16/32/64-bit fetch with 1x/2x/4x pixel magnification.
// Optional feature macro: SPR_FINE_HPOS_EN (CTL[4:3] sub-pixel start offset).
module denise_sprite_shifter_gen #(
   parameter int FETCH_MAX = 64,
   parameter int LOAD_DLY  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk7_en,
   input  logic        aen,
   input  logic [1:0]  address,
   input  logic [8:0]  hpos,
   input  logic [15:0] fmode,
   input  logic [1:0]  mag,
   input  logic        shift,
   input  logic [47:0] chip48,
   input  logic [15:0] data_in,
   output logic [1:0]  sprdata,
   output logic        attach,
   output logic        active
);

   localparam int CW = $clog2(FETCH_MAX) + 1;

   // register file
   logic [8:0]           hstart_q;
   logic                 attach_q;
   logic                 armed_q;
   logic [FETCH_MAX-1:0] data_a_q;
   logic [FETCH_MAX-1:0] data_b_q;

   // load pipeline
   logic [LOAD_DLY-1:0]  pipe_q;
   logic                 match;
   logic                 load;

   // shifter state
   logic [FETCH_MAX-1:0] shifta_q, shifta_d;
   logic [FETCH_MAX-1:0] shiftb_q, shiftb_d;
   logic [CW-1:0]        pix_cnt_q, pix_cnt_d;
   logic [1:0]           hold_cnt_q, hold_cnt_d;
   logic                 active_q, active_d;
   logic [1:0]           hold_lim;
   logic                 fine_busy;

   // fetch width and latch formatting
   logic [6:0]           width7;
   logic [CW-1:0]        width_w;
   logic [63:0]          fetch_full;
   logic [63:0]          fetch_mask;
   logic [63:0]          fetch_masked;
   logic [FETCH_MAX-1:0] latch_value;
   logic                 wr_en;

   // only fetch width and the hstart[8] ignore bit are meaningful in fmode
   logic unused_fmode;
   assign unused_fmode = ^{fmode[14:4], fmode[1:0]};

   // decode the effective fetch width, clipped to what this instance supports
   always_comb begin
      case (fmode[3:2])
         2'b00:   width7 = 7'd16;
         2'b11:   width7 = 7'd64;
         default: width7 = 7'd32;
      endcase
      if (width7 > 7'(FETCH_MAX)) width7 = 7'(FETCH_MAX);
   end

   assign width_w      = width7[CW-1:0];
   assign fetch_full   = {data_in, chip48};
   assign fetch_mask   = ~(64'hFFFF_FFFF_FFFF_FFFF >> width7);
   assign fetch_masked = fetch_full & fetch_mask;
   assign latch_value  = fetch_masked[63 -: FETCH_MAX];
   assign wr_en        = clk7_en & aen;

`ifdef SPR_FINE_HPOS_EN
   logic [1:0] hfine_q;
   logic [1:0] fine_cnt_q, fine_cnt_d;
   assign fine_busy = (fine_cnt_q != 2'd0);
`else
   assign fine_busy = 1'b0;
`endif

   // register writes; CTL disarms, DATA arms
   always_ff @(posedge clk) begin
      if (reset) begin
         hstart_q <= '0;
         attach_q <= 1'b0;
         armed_q  <= 1'b0;
         data_a_q <= '0;
         data_b_q <= '0;
`ifdef SPR_FINE_HPOS_EN
         hfine_q  <= '0;
`endif
      end else if (wr_en) begin
         case (address)
            2'b00: hstart_q[8:1] <= data_in[7:0];
            2'b01: begin
               hstart_q[0] <= data_in[0];
               attach_q    <= data_in[7];
               armed_q     <= 1'b0;
`ifdef SPR_FINE_HPOS_EN
               hfine_q     <= data_in[4:3];
`endif
            end
            2'b10: begin
               data_a_q <= latch_value;
               armed_q  <= 1'b1;
            end
            default: data_b_q <= latch_value;
         endcase
      end
   end

   assign match = armed_q && (hpos[7:0] == hstart_q[7:0]) &&
                  (fmode[15] || (hpos[8] == hstart_q[8]));

   // delay the start match by LOAD_DLY 7MHz ticks
   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_q <= '0;
      end else if (clk7_en) begin
         pipe_q[0] <= match;
         for (int i = 1; i < LOAD_DLY; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign load = clk7_en & pipe_q[LOAD_DLY-1];

   always_comb begin
      case (mag)
         2'b00:   hold_lim = 2'd0;
         2'b01:   hold_lim = 2'd1;
         default: hold_lim = 2'd3;
      endcase
   end

   // shifter next state: load beats shift; a shift only counts while active
   always_comb begin
      shifta_d   = shifta_q;
      shiftb_d   = shiftb_q;
      pix_cnt_d  = pix_cnt_q;
      hold_cnt_d = hold_cnt_q;
      active_d   = active_q;
`ifdef SPR_FINE_HPOS_EN
      fine_cnt_d = fine_cnt_q;
`endif
      if (load) begin
         shifta_d   = data_a_q;
         shiftb_d   = data_b_q;
         pix_cnt_d  = width_w;
         hold_cnt_d = 2'd0;
         active_d   = 1'b1;
`ifdef SPR_FINE_HPOS_EN
         fine_cnt_d = hfine_q;
`endif
      end else if (shift && active_q) begin
         if (fine_busy) begin
`ifdef SPR_FINE_HPOS_EN
            fine_cnt_d = fine_cnt_q - 2'd1;
`endif
         end else if (hold_cnt_q >= hold_lim) begin
            // a lowered mag mid-pixel wraps right away instead of overrunning
            hold_cnt_d = 2'd0;
            shifta_d   = {shifta_q[FETCH_MAX-2:0], 1'b0};
            shiftb_d   = {shiftb_q[FETCH_MAX-2:0], 1'b0};
            pix_cnt_d  = pix_cnt_q - CW'(1);
            if (pix_cnt_q == CW'(1)) active_d = 1'b0;
         end else begin
            hold_cnt_d = hold_cnt_q + 2'd1;
         end
      end
   end

   // shifter state register
   always_ff @(posedge clk) begin
      if (reset) begin
         shifta_q   <= '0;
         shiftb_q   <= '0;
         pix_cnt_q  <= '0;
         hold_cnt_q <= '0;
         active_q   <= 1'b0;
`ifdef SPR_FINE_HPOS_EN
         fine_cnt_q <= '0;
`endif
      end else begin
         shifta_q   <= shifta_d;
         shiftb_q   <= shiftb_d;
         pix_cnt_q  <= pix_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         active_q   <= active_d;
`ifdef SPR_FINE_HPOS_EN
         fine_cnt_q <= fine_cnt_d;
`endif
      end
   end

   assign sprdata = (active_q && !fine_busy) ?
                    {shiftb_q[FETCH_MAX-1], shifta_q[FETCH_MAX-1]} : 2'b00;
   assign attach  = attach_q;
   assign active  = active_q;

endmodule
